cache_ewb: RTL and testbench

CACHE_EWB -- requirements
Module: cache_ewb

---
 rtl/cache_ewb_pkg.sv | 15 +
 rtl/cache_ewb.sv | 116 +++++++++++
 tb/tb_cache_ewb.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ewb_pkg.sv
// Shared LC-3b datapath types and the write-back buffer state encoding.
package lc3b_types;
   typedef logic [15:0] lc3b_word;
endpackage

package cache_types;
   typedef logic [127:0] cache_line;

   typedef enum logic [1:0] {
      IDLE,
      PREAD,
      DRAIN,
      RESP
   } ewb_state_t;
endpackage

// File: rtl/cache_ewb.sv
// Single-entry eviction write-back buffer between the L1 cache and physical memory.
// Define CACHE_EWB_FWD_EN to serve reads that hit the buffered line directly from the entry.
module cache_ewb
   import lc3b_types::*;
   import cache_types::*;
#(
   parameter int unsigned DRAIN_DELAY = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      mem_read,
   input  logic      mem_write,
   input  lc3b_word  mem_address,
   input  cache_line mem_wdata,
   output cache_line mem_rdata,
   output logic      mem_resp,
   output logic      pmem_read,
   output logic      pmem_write,
   output lc3b_word  pmem_address,
   output cache_line pmem_wdata,
   input  cache_line pmem_rdata,
   input  logic      pmem_resp
);

   localparam int unsigned CW = $clog2(DRAIN_DELAY + 2);

   ewb_state_t state, next_state;

   logic          valid;
   lc3b_word      addr;
   cache_line     data;
   lc3b_word      rd_addr;
   logic [CW-1:0] count;

   logic request;
   logic line_hit;
   logic drain_due;

   assign request   = mem_read | mem_write;
   assign line_hit  = valid && (addr[15:4] == mem_address[15:4]);
   assign drain_due = valid && (count >= CW'(DRAIN_DELAY));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Requests take priority over the autonomous drain in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (mem_write) begin
               next_state = valid ? DRAIN : RESP;
            end else if (mem_read) begin
               if (!line_hit) next_state = PREAD;
`ifdef CACHE_EWB_FWD_EN
               else           next_state = RESP;
`else
               else           next_state = DRAIN;
`endif
            end else if (drain_due) begin
               next_state = DRAIN;
            end
         end
         PREAD:   if (pmem_resp) next_state = RESP;
         DRAIN:   if (pmem_resp) next_state = IDLE;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid     <= 1'b0;
         addr      <= '0;
         data      <= '0;
         rd_addr   <= '0;
         count     <= '0;
         mem_rdata <= '0;
      end else begin
         if ((state == IDLE) && (next_state == IDLE) && valid && !request)
            count <= count + CW'(1);
         else
            count <= '0;

         case (state)
            IDLE: begin
               if (mem_write) begin
                  if (!valid) begin
                     valid <= 1'b1;
                     addr  <= mem_address;
                     data  <= mem_wdata;
                  end
               end else if (mem_read) begin
                  if (!line_hit) rd_addr <= mem_address;
`ifdef CACHE_EWB_FWD_EN
                  else           mem_rdata <= data;
`endif
               end
            end
            PREAD: if (pmem_resp) mem_rdata <= pmem_rdata;
            DRAIN: if (pmem_resp) valid <= 1'b0;
            default: ;
         endcase
      end
   end

   assign mem_resp     = (state == RESP);
   assign pmem_read    = (state == PREAD);
   assign pmem_write   = (state == DRAIN);
   assign pmem_address = (state == PREAD) ? rd_addr :
                         (state == DRAIN) ? addr    : '0;
   assign pmem_wdata   = (state == DRAIN) ? data : '0;

endmodule

// File: tb/tb_cache_ewb.sv
// Randomized bench for cache_ewb against a transaction-level model of the buffer.
module tb_cache_ewb;
   import lc3b_types::*;
   import cache_types::*;

   localparam int unsigned DD = 2;

   logic      clk = 1'b0;
   logic      reset = 1'b1;
   logic      mem_read = 1'b0;
   logic      mem_write = 1'b0;
   lc3b_word  mem_address = '0;
   cache_line mem_wdata = '0;
   cache_line mem_rdata;
   logic      mem_resp;
   logic      pmem_read;
   logic      pmem_write;
   lc3b_word  pmem_address;
   cache_line pmem_wdata;
   cache_line pmem_rdata = '0;
   logic      pmem_resp = 1'b0;

   always #5 clk = ~clk;

   cache_ewb #(.DRAIN_DELAY(DD)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      cache_line   data;
      cache_line   rdata;
   } op_t;

   op_t exp_q[$];
   op_t act_q[$];

   int unsigned n_vec = 0;
   int unsigned n_mis = 0;

   // Model of the buffered entry, tracked per transaction.
   bit          m_valid = 1'b0;
   logic [15:0] m_addr = '0;
   cache_line   m_data = '0;

   int unsigned resp_delay = 0;
   bit          checking = 1'b0;
   logic [11:0] lines [4] = '{12'h123, 12'h456, 12'h777, 12'hABC};

   task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
      n_vec++;
      if (!ok) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   endtask

   function automatic cache_line rand_line();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic op_t mk_op(input bit wr, input logic [15:0] a, input cache_line d);
      op_t o;
      o.wr = wr;
      o.addr = a;
      o.data = d;
      o.rdata = '0;
      return o;
   endfunction

   // Physical memory: answers each request after a delay and logs it.
   initial begin : responder
      forever begin
         @(posedge clk); #1;
         if (pmem_read || pmem_write) begin
            op_t o;
            int unsigned d;
            o.wr = pmem_write;
            o.addr = pmem_address;
            o.data = pmem_wdata;
            d = (resp_delay != 0) ? resp_delay : $urandom_range(1, 4);
            repeat (d - 1) begin @(posedge clk); #1; end
            o.rdata = rand_line();
            pmem_rdata = o.rdata;
            pmem_resp = 1'b1;
            if (o.wr ? pmem_write : pmem_read) act_q.push_back(o);
            @(posedge clk); #1;
            pmem_resp = 1'b0;
         end
      end
   end

   // Per-cycle protocol checks.
   initial begin : monitor
      logic      prev_resp;
      logic      prev_rst;
      cache_line prev_rdata;
      prev_resp = 1'b0;
      prev_rst = 1'b1;
      prev_rdata = '0;
      forever begin
         @(negedge clk);
         if (checking) begin
            chk(!(pmem_read && pmem_write), "pmem_excl", {pmem_read, pmem_write}, 0);
            chk(!(mem_resp && prev_resp), "resp_pulse", mem_resp, 0);
            chk(prev_rst || mem_resp || (mem_rdata === prev_rdata), "rdata_hold", mem_rdata, prev_rdata);
         end
         prev_resp = mem_resp;
         prev_rst = reset;
         prev_rdata = mem_rdata;
      end
   end

   initial begin : watchdog
      #1_000_000;
      n_mis++;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      finish_run();
   end

   // Idle gap after a completed transaction; a full entry must drain after DD+1 idle cycles.
   task automatic do_gap(input int unsigned g, output int first_w);
      bit due;
      first_w = -1;
      for (int j = 0; j < int'(g); j++) begin
         @(posedge clk); #1;
         if (pmem_write && first_w < 0) first_w = j;
         chk(!mem_resp, "spurious_resp", mem_resp, 0);
      end
      due = m_valid && (g >= DD + 2);
      chk(first_w == (due ? int'(DD + 1) : -1), "drain_start", first_w, due ? DD + 1 : -1);
      if (due) begin
         exp_q.push_back(mk_op(1'b1, m_addr, m_data));
         m_valid = 1'b0;
      end
   endtask

   task automatic check_ops(output cache_line rd);
      rd = '0;
      while (exp_q.size() > 0) begin
         op_t e;
         op_t a;
         e = exp_q.pop_front();
         chk(act_q.size() != 0, "op_missing", e.addr, e.wr);
         if (act_q.size() != 0) begin
            a = act_q.pop_front();
            chk(a.wr == e.wr, "op_kind", a.wr, e.wr);
            chk(a.addr == e.addr, "op_addr", a.addr, e.addr);
            if (e.wr) chk(a.data == e.data, "op_wdata", a.data, e.data);
            else      rd = a.rdata;
         end
      end
      chk(act_q.size() == 0, "op_extra", act_q.size(), 0);
      act_q.delete();
   endtask

   task automatic xact(input bit wr, input lc3b_word a, input cache_line d,
                       input int unsigned g, output int unsigned lat);
      int        fw;
      bit        drained;
      bit        fast;
      bit        hit;
      bit        fwd_hit;
      cache_line exp_rd;
      cache_line got_rd;
      drained = m_valid && (g >= DD + 2);
      do_gap(g, fw);
      fast = 1'b0;
      fwd_hit = 1'b0;
      exp_rd = '0;
      mem_address = a;
      mem_wdata = d;
      if (wr) begin
         mem_write = 1'b1;
         if (m_valid) exp_q.push_back(mk_op(1'b1, m_addr, m_data));
         fast = !m_valid && !drained;
         m_valid = 1'b1;
         m_addr = a;
         m_data = d;
      end else begin
         mem_read = 1'b1;
         hit = m_valid && (a[15:4] == m_addr[15:4]);
`ifdef CACHE_EWB_FWD_EN
         if (hit) begin
            fwd_hit = 1'b1;
            exp_rd = m_data;
            fast = 1'b1;
         end else begin
            exp_q.push_back(mk_op(1'b0, a, '0));
         end
`else
         if (hit) begin
            exp_q.push_back(mk_op(1'b1, m_addr, m_data));
            m_valid = 1'b0;
         end
         exp_q.push_back(mk_op(1'b0, a, '0));
`endif
      end
      for (lat = 1; lat <= 300; lat++) begin
         @(posedge clk); #1;
         if (mem_resp) break;
      end
      chk(mem_resp == 1'b1, "resp_timeout", lat, 300);
      if (!mem_resp) finish_run();
      mem_read = 1'b0;
      mem_write = 1'b0;
      if (fast) chk(lat == 1, "resp_latency", lat, 1);
      check_ops(got_rd);
      if (!wr) chk(mem_rdata == (fwd_hit ? exp_rd : got_rd), "mem_rdata", mem_rdata, fwd_hit ? exp_rd : got_rd);
   endtask

   initial begin : main
      int unsigned lat;
      int          fw;
      bit          found;
      cache_line   A;
      cache_line   B;
      cache_line   rd;

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk(mem_resp == 1'b0, "rst_mem_resp", mem_resp, 0);
      chk(mem_rdata == '0, "rst_mem_rdata", mem_rdata, 0);
      chk(pmem_read == 1'b0, "rst_pmem_read", pmem_read, 0);
      chk(pmem_write == 1'b0, "rst_pmem_write", pmem_write, 0);
      chk(pmem_address == '0, "rst_pmem_address", pmem_address, 0);
      chk(pmem_wdata == '0, "rst_pmem_wdata", pmem_wdata, 0);
      reset = 1'b0;
      checking = 1'b1;

      A = rand_line();
      B = rand_line();

      // Capture into an empty buffer, then an autonomous drain after the idle delay.
      xact(1'b1, 16'h1230, A, 1, lat);
      chk(lat == 1, "wr_empty_latency", lat, 1);
      do_gap(DD + 8, fw);
      chk(fw == 3, "autodrain_cycle", fw, 3);
      chk(act_q.size() == 1 && act_q[0].addr == 16'h1230 && act_q[0].data == A,
          "autodrain_op", act_q.size(), 1);
      check_ops(rd);

      // Write into a full buffer drains the old line first.
      xact(1'b1, 16'h1230, A, 1, lat);
      xact(1'b1, 16'h4560, B, 1, lat);
      chk(lat >= 3, "wr_full_latency", lat, 3);
      do_gap(DD + 8, fw);
      check_ops(rd);

      // Read hitting the buffered line.
      xact(1'b1, 16'h1230, A, 1, lat);
      xact(1'b0, 16'h1238, '0, 1, lat);
`ifdef CACHE_EWB_FWD_EN
      chk(lat == 1, "fwd_latency", lat, 1);
      chk(mem_rdata == A, "fwd_data", mem_rdata, A);
`endif
      do_gap(DD + 8, fw);
      check_ops(rd);

      // Miss on an empty buffer with a slow physical memory.
      resp_delay = 5;
      xact(1'b0, 16'h7770, '0, 1, lat);
      chk(lat == 6, "miss_latency", lat, 6);
      resp_delay = 0;

      // Read arriving exactly at the drain threshold wins.
      xact(1'b1, 16'h1230, A, 1, lat);
      xact(1'b0, 16'h7770, '0, DD + 1, lat);
      do_gap(DD + 8, fw);
      check_ops(rd);

      // Reset in the middle of a drain loses the entry; the late pmem_resp is ignored.
      resp_delay = 4;
      xact(1'b1, 16'h1230, A, 1, lat);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (pmem_write) begin
            found = 1'b1;
            break;
         end
      end
      chk(found, "drain_seen", found, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk(pmem_write == 1'b0, "rst_drop_write", pmem_write, 0);
      chk(pmem_address == '0, "rst_drop_addr", pmem_address, 0);
      reset = 1'b0;
      m_valid = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      check_ops(rd);
      resp_delay = 0;
      xact(1'b0, 16'h1234, '0, 1, lat);

      for (int n = 0; n < 200; n++) begin
         bit       w;
         lc3b_word a;
         w = 1'($urandom_range(0, 1));
         a = {lines[$urandom_range(0, 3)], 4'($urandom())};
         xact(w, a, rand_line(), $urandom_range(1, DD + 4), lat);
      end
      do_gap(DD + 12, fw);
      check_ops(rd);

      finish_run();
   end

endmodule
